// File: rtl/ex_muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the iterative RV32M multiply/divide unit.
// master = pipeline side, slave = ex_muldiv_unit.
interface ex_muldiv_unit_if;
  logic        START;
  logic        ABORT;
  logic        HOLD;
  logic [2:0]  FUNCT3;
  logic [31:0] OPERAND1;
  logic [31:0] OPERAND2;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  modport master (
    output START, ABORT, HOLD, FUNCT3, OPERAND1, OPERAND2,
    input  RESULT, BUSY, DONE
  );

  modport slave (
    input  START, ABORT, HOLD, FUNCT3, OPERAND1, OPERAND2,
    output RESULT, BUSY, DONE
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide (shift-add / restoring, 32 CALC cycles per op).
// Define MULDIV_SPECIAL_FASTPATH_EN to finish divide-by-zero and signed overflow at the issue edge.
module ex_muldiv_unit (
  input  logic            CLK,
  input  logic            RESET_N,
  ex_muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
  state_t state, state_nxt;

  logic [5:0]  cnt;
  logic [2:0]  op;
  logic [31:0] mag_b;     // multiplicand / divisor magnitude
  logic [31:0] acc_hi;    // product high half / partial remainder
  logic [31:0] acc_lo;    // multiplier then product low half / dividend then quotient
  logic [31:0] result_q;
  logic        neg_res;

  logic        issue;
  logic [2:0]  f;
  logic        a_sgn, b_sgn, a_neg, b_neg, div0_in, neg_in, fast_hit;
  logic [31:0] a_mag, b_mag;

  assign f     = bus.FUNCT3;
  assign issue = (state == S_IDLE) && bus.START && !bus.ABORT;

  assign a_sgn = (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
  assign b_sgn = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
  assign a_neg = a_sgn && bus.OPERAND1[31];
  assign b_neg = b_sgn && bus.OPERAND2[31];
  assign a_mag = a_neg ? (~bus.OPERAND1 + 32'd1) : bus.OPERAND1;
  assign b_mag = b_neg ? (~bus.OPERAND2 + 32'd1) : bus.OPERAND2;

  assign div0_in = f[2] && (bus.OPERAND2 == '0);
  // x/0 gives an all-ones magnitude quotient; dropping its sign makes DIV read all ones too,
  // while REM keeps the dividend sign and so returns OPERAND1 unchanged.
  assign neg_in  = f[2] ? (f[1] ? a_neg : ((a_neg ^ b_neg) && !div0_in)) : (a_neg ^ b_neg);

`ifdef MULDIV_SPECIAL_FASTPATH_EN
  logic        ovf_in;
  logic [31:0] special_res;
  assign ovf_in      = f[2] && !f[0] && (bus.OPERAND1 == 32'h8000_0000) && (bus.OPERAND2 == '1);
  assign fast_hit    = div0_in || ovf_in;
  assign special_res = div0_in ? (f[1] ? bus.OPERAND1 : '1) : (f[1] ? '0 : 32'h8000_0000);
`else
  assign fast_hit = 1'b0;
`endif

  // One iteration of either algorithm on the current accumulator pair.
  logic [32:0] mul_sum, div_shift;
  logic        div_ge;
  logic [31:0] iter_hi, iter_lo;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : 33'd0);
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ge    = div_shift >= {1'b0, mag_b};

  always_comb begin
    iter_hi = acc_hi;
    iter_lo = acc_lo;
    if (op[2]) begin
      iter_hi = div_ge ? (div_shift[31:0] - mag_b) : div_shift[31:0];
      iter_lo = {acc_lo[30:0], div_ge};
    end else begin
      iter_hi = mul_sum[32:1];
      iter_lo = {mul_sum[0], acc_lo[31:1]};
    end
  end

  // Sign applied to the post-final-iteration values, registered on entry to DONE.
  logic [63:0] prod_s;
  logic [31:0] quo_s, rem_s, final_res;

  assign prod_s = neg_res ? (~{iter_hi, iter_lo} + 64'd1) : {iter_hi, iter_lo};
  assign quo_s  = neg_res ? (~iter_lo + 32'd1) : iter_lo;
  assign rem_s  = neg_res ? (~iter_hi + 32'd1) : iter_hi;

  always_comb begin
    final_res = rem_s;
    case (op)
      3'b000:                 final_res = prod_s[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[63:32];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (issue) state_nxt = fast_hit ? S_DONE : S_CALC;
      S_CALC: begin
        if (bus.ABORT)           state_nxt = S_IDLE;
        else if (cnt == 6'd31)   state_nxt = S_DONE;
      end
      S_DONE: if (bus.ABORT || !bus.HOLD) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt      <= '0;
      op       <= '0;
      mag_b    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      neg_res  <= 1'b0;
      result_q <= '0;
    end else if (issue) begin
      op      <= f;
      mag_b   <= b_mag;
      acc_hi  <= '0;
      acc_lo  <= a_mag;
      neg_res <= neg_in;
      cnt     <= '0;
`ifdef MULDIV_SPECIAL_FASTPATH_EN
      if (fast_hit) result_q <= special_res;
`endif
    end else if ((state == S_CALC) && !bus.ABORT) begin
      acc_hi <= iter_hi;
      acc_lo <= iter_lo;
      cnt    <= cnt + 6'd1;
      if (cnt == 6'd31) result_q <= final_res;
    end
  end

  assign bus.BUSY   = RESET_N && (issue || (state == S_CALC));
  assign bus.DONE   = (state == S_DONE);
  assign bus.RESULT = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: arithmetic model, latency, HOLD/ABORT and reset behaviour.
module tb_ex_muldiv_unit;
  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

`ifdef MULDIV_SPECIAL_FASTPATH_EN
  localparam int FAST_LAT = 2;
`else
  localparam int FAST_LAT = 34;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_res = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub_s;
    logic [63:0] p;
    logic [31:0] r;
    logic        ovf;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub_s = longint'({32'd0, b});
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = '0;
    r = '0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0];  end
      3'd1: begin p = 64'(sa * sb);            r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub_s);          r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bit special;
    special = f[2] && ((b == 0) || (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    return special ? FAST_LAT : 34;
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int hold_n, input bit abort_done);
    int lat, busy_n;
    logic [31:0] exp;
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = f; bus.OPERAND1 = a; bus.OPERAND2 = b;
    sb_q.push_back(model(f, a, b));
    #1;
    check("idle_done", 32'(bus.DONE), 32'd0);
    lat = 0; busy_n = 0;
    forever begin
      lat++;
      if (bus.DONE) break;
      if (bus.BUSY) busy_n++;
      if (lat > 100) break;
      @(negedge CLK);
      bus.START = 1'b0; bus.OPERAND1 = $urandom; bus.OPERAND2 = $urandom;
      bus.FUNCT3 = 3'($urandom_range(0, 7));
      #1;
    end
    exp = sb_q.pop_front();
    check("latency", 32'(lat), 32'(exp_lat(f, a, b)));
    if (lat > 100) begin
      bus.START = 1'b0;
      return;
    end
    check("busy_cycles", 32'(busy_n), 32'(lat - 1));
    check("busy_in_done", 32'(bus.BUSY), 32'd0);
    check("result", bus.RESULT, exp);
    last_res = exp;
    for (int i = 0; i < hold_n; i++) begin
      bus.HOLD = 1'b1; bus.START = 1'b1;
      @(negedge CLK); #1;
      check("hold_done", 32'(bus.DONE), 32'd1);
      check("hold_result", bus.RESULT, exp);
    end
    bus.START = 1'b0;
    if (abort_done) begin
      bus.HOLD = 1'b1; bus.ABORT = 1'b1;
      @(negedge CLK); #1;
      bus.ABORT = 1'b0;
      check("abort_in_done", 32'(bus.DONE), 32'd0);
      check("abort_keep", bus.RESULT, exp);
    end
    bus.HOLD = 1'b0;
  endtask

  initial begin
    int done_seen;
    RESET_N = 1'b0;
    bus.START = 1'b1; bus.ABORT = 1'b0; bus.HOLD = 1'b0;
    bus.FUNCT3 = '0; bus.OPERAND1 = '0; bus.OPERAND2 = '0;
    #1;
    check("rst_result", bus.RESULT, 32'd0);
    check("rst_done", 32'(bus.DONE), 32'd0);
    check("rst_busy", 32'(bus.BUSY), 32'd0);
    bus.START = 1'b0;
    #16 RESET_N = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    run_op(3'd5, 32'd100, 32'd0, 0, 1'b0);
    run_op(3'd7, 32'd100, 32'd0, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 2, 1'b1);

    // START together with ABORT in IDLE must not issue
    @(negedge CLK);
    bus.START = 1'b1; bus.ABORT = 1'b1; bus.FUNCT3 = 3'd0;
    #1;
    check("idle_abort_busy", 32'(bus.BUSY), 32'd0);
    @(negedge CLK);
    bus.START = 1'b0; bus.ABORT = 1'b0;
    #1;
    check("idle_abort_state", 32'({bus.BUSY, bus.DONE}), 32'd0);

    // ABORT at CALC cycle 10
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'd0; bus.OPERAND1 = 32'd3; bus.OPERAND2 = 32'd5;
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); bus.START = 1'b0; #1;
    end
    bus.ABORT = 1'b1; bus.START = 1'b1;
    @(negedge CLK); #1;
    bus.ABORT = 1'b0; bus.START = 1'b0;
    #1;
    check("abort_busy", 32'(bus.BUSY), 32'd0);
    check("abort_done", 32'(bus.DONE), 32'd0);
    check("abort_result", bus.RESULT, last_res);
    done_seen = 0;
    repeat (40) begin
      @(negedge CLK); #1;
      if (bus.DONE) done_seen++;
    end
    check("no_done_after_abort", 32'(done_seen), 32'd0);

    // reset pulse at CALC cycle 20, then DIVU 9/4 at the first edge after release
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNCT3 = 3'd4; bus.OPERAND1 = 32'd1000; bus.OPERAND2 = 32'd3;
    #1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); bus.START = 1'b0; #1;
    end
    bus.START = 1'b1;
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_result", bus.RESULT, 32'd0);
    check("midrst_done", 32'(bus.DONE), 32'd0);
    check("midrst_busy", 32'(bus.BUSY), 32'd0);
    last_res = '0;
    @(posedge CLK);
    #2;
    RESET_N = 1'b1; bus.START = 1'b0;
    run_op(3'd5, 32'd9, 32'd4, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 9));
      run_op(rf, ra, rb, i % 3, 1'b0);
    end

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
